// File: rtl/placar_basquete_n_if.sv
// Scoreboard bus: buttons/controls in, scores, BCD and indicators out.
// Optional undo line exists only when PLACAR_UNDO_EN is defined.
interface placar_basquete_n_if #(
  parameter int NUM_TIMES = 2,
  parameter int SCORE_W   = 7,
  parameter int DIGITS    = 2,
  parameter int TEAM_W    = 1
);
  logic btn_1;
  logic btn_2;
  logic btn_3;
  logic subtract;
  logic [TEAM_W-1:0] team_sel;
  logic clear;
`ifdef PLACAR_UNDO_EN
  logic undo;
`endif
  logic [NUM_TIMES*SCORE_W-1:0]  scores;
  logic [NUM_TIMES*DIGITS*4-1:0] bcd;
  logic invalid_led;
  logic overflow_led;
  logic buzzer;

  modport master (
`ifdef PLACAR_UNDO_EN
    output undo,
`endif
    output btn_1, btn_2, btn_3,
    output subtract, team_sel, clear,
    input  scores, bcd,
    input  invalid_led, overflow_led, buzzer
  );

  modport slave (
`ifdef PLACAR_UNDO_EN
    input  undo,
`endif
    input  btn_1, btn_2, btn_3,
    input  subtract, team_sel, clear,
    output scores, bcd,
    output invalid_led, overflow_led, buzzer
  );
endinterface

// File: rtl/placar_basquete_n.sv
// Registered N-team basketball scoreboard with saturation and buzzer.
// Optional one-deep undo enabled by defining PLACAR_UNDO_EN.
module placar_basquete_n #(
  parameter int NUM_TIMES   = 2,
  parameter int SCORE_W     = 7,
  parameter int SCORE_MAX   = 99,
  parameter int DIGITS      = 2,
  parameter int BUZZ_CYCLES = 1000,
  parameter int TEAM_W      = 1
) (
  input  logic clk,
  input  logic rst_n,
  placar_basquete_n_if.slave bus
);

  localparam int AW = SCORE_W + 2;
  localparam int CW = $clog2(BUZZ_CYCLES) + 1;
  localparam int BW = DIGITS * 4;
  localparam logic [AW-1:0] SMAX = AW'(SCORE_MAX);
  localparam logic [CW-1:0] CLOAD = CW'(BUZZ_CYCLES - 1);
`ifdef PLACAR_UNDO_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  typedef enum logic {IDLE, BUZZ} bz_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q, s2_q, h_q, ev;

  logic [SCORE_W-1:0] scores_q [NUM_TIMES];
  logic [SCORE_W-1:0] scores_d [NUM_TIMES];
  logic [BW-1:0]      bcd_q    [NUM_TIMES];
  logic inv_q, inv_d;
  logic ovf_q, ovf_d;
  logic sat;
  logic wr;
  logic sel_ok;
  logic [AW-1:0] cur, v, sum, nxt;

  bz_t state_q;
  logic [CW-1:0] cnt_q;
  logic buzz_q;

`ifdef PLACAR_UNDO_EN
  logic hv_q, hv_d;
  logic [TEAM_W-1:0] ht_q, ht_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  assign raw = {bus.undo, bus.btn_3, bus.btn_2, bus.btn_1};
`else
  assign raw = {bus.btn_3, bus.btn_2, bus.btn_1};
`endif

  assign ev = s2_q & ~h_q;
  assign sel_ok = int'({1'b0, bus.team_sel}) < NUM_TIMES;

  function automatic logic [BW-1:0] to_bcd(
    input logic [SCORE_W-1:0] b
  );
    logic [BW-1:0] r;
    r = '0;
    for (int i = SCORE_W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (r[d*4 +: 4] >= 4'd5)
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
      end
      r = {r[BW-2:0], b[i]};
    end
    return r;
  endfunction

  always_comb begin
    scores_d = scores_q;
    inv_d = inv_q;
    ovf_d = ovf_q;
    sat = 1'b0;
    wr = 1'b0;
    nxt = '0;
    cur = '0;
`ifdef PLACAR_UNDO_EN
    hv_d = hv_q;
    ht_d = ht_q;
    hs_d = hs_q;
`endif
    for (int i = 0; i < NUM_TIMES; i++) begin
      if (bus.team_sel == TEAM_W'(i))
        cur = AW'(scores_q[i]);
    end
    if (ev[2])      v = AW'(3);
    else if (ev[1]) v = AW'(2);
    else            v = AW'(1);
    sum = cur + v;

    if (bus.clear) begin
      for (int i = 0; i < NUM_TIMES; i++)
        scores_d[i] = '0;
      inv_d = 1'b0;
      ovf_d = 1'b0;
`ifdef PLACAR_UNDO_EN
      hv_d = 1'b0;
`endif
    end else if (|ev[2:0]) begin
      if (!sel_ok) begin
        inv_d = 1'b1;
      end else if (!bus.subtract) begin
        wr = 1'b1;
        inv_d = 1'b0;
        if (sum > SMAX) begin
          nxt = SMAX;
          ovf_d = 1'b1;
          sat = 1'b1;
        end else begin
          nxt = sum;
          ovf_d = 1'b0;
        end
      end else if (cur < v) begin
        inv_d = 1'b1;
        ovf_d = 1'b0;
      end else begin
        wr = 1'b1;
        nxt = cur - v;
        inv_d = 1'b0;
        ovf_d = 1'b0;
      end
    end
`ifdef PLACAR_UNDO_EN
    else if (ev[3]) begin
      if (hv_q) begin
        for (int i = 0; i < NUM_TIMES; i++) begin
          if (ht_q == TEAM_W'(i))
            scores_d[i] = hs_q;
        end
        hv_d = 1'b0;
        inv_d = 1'b0;
        ovf_d = 1'b0;
      end else begin
        inv_d = 1'b1;
      end
    end
`endif

    if (wr) begin
      for (int i = 0; i < NUM_TIMES; i++) begin
        if (bus.team_sel == TEAM_W'(i))
          scores_d[i] = nxt[SCORE_W-1:0];
      end
`ifdef PLACAR_UNDO_EN
      hv_d = 1'b1;
      ht_d = bus.team_sel;
      hs_d = cur[SCORE_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      h_q <= '0;
      inv_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int i = 0; i < NUM_TIMES; i++) begin
        scores_q[i] <= '0;
        bcd_q[i] <= '0;
      end
`ifdef PLACAR_UNDO_EN
      hv_q <= 1'b0;
      ht_q <= '0;
      hs_q <= '0;
`endif
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      h_q <= s2_q;
      inv_q <= inv_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_TIMES; i++) begin
        scores_q[i] <= scores_d[i];
        bcd_q[i] <= to_bcd(scores_q[i]);
      end
`ifdef PLACAR_UNDO_EN
      hv_q <= hv_d;
      ht_q <= ht_d;
      hs_q <= hs_d;
`endif
    end
  end

  // A saturating add always (re)loads the full on-time.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      state_q <= IDLE;
      cnt_q <= '0;
      buzz_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sat) begin
            state_q <= BUZZ;
            cnt_q <= CLOAD;
            buzz_q <= 1'b1;
          end
        end
        BUZZ: begin
          if (sat) begin
            cnt_q <= CLOAD;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
            buzz_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          buzz_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_TIMES; g++) begin : g_out
    assign bus.scores[g*SCORE_W +: SCORE_W] = scores_q[g];
    assign bus.bcd[g*BW +: BW] = bcd_q[g];
  end

  assign bus.invalid_led = inv_q;
  assign bus.overflow_led = ovf_q;
  assign bus.buzzer = buzz_q;

endmodule

// File: tb/tb_placar_basquete_n.sv
// Directed bench: default 2-team instance plus a 3-team,
// small-ceiling instance for team_sel range and clear-mid-buzz.
module tb_placar_basquete_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic b1, b2, b3, sub;
  logic clr_a, clr_b;
  logic [1:0] tsel;
  logic [3:0] umask;
  int nerr = 0;
  int nchk = 0;
  int n;

  placar_basquete_n_if #(
    .NUM_TIMES(2), .SCORE_W(7),
    .DIGITS(2), .TEAM_W(1)
  ) ia ();

  placar_basquete_n_if #(
    .NUM_TIMES(3), .SCORE_W(4),
    .DIGITS(1), .TEAM_W(2)
  ) ib ();

  assign ia.btn_1 = b1;
  assign ia.btn_2 = b2;
  assign ia.btn_3 = b3;
  assign ia.subtract = sub;
  assign ia.team_sel = tsel[0];
  assign ia.clear = clr_a;
  assign ib.btn_1 = b1;
  assign ib.btn_2 = b2;
  assign ib.btn_3 = b3;
  assign ib.subtract = sub;
  assign ib.team_sel = tsel;
  assign ib.clear = clr_b;
`ifdef PLACAR_UNDO_EN
  logic und;
  assign ia.undo = und;
  assign ib.undo = und;
`endif

  placar_basquete_n #(
    .NUM_TIMES(2), .SCORE_W(7),
    .SCORE_MAX(99), .DIGITS(2),
    .BUZZ_CYCLES(1000), .TEAM_W(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );

  placar_basquete_n #(
    .NUM_TIMES(3), .SCORE_W(4),
    .SCORE_MAX(9), .DIGITS(1),
    .BUZZ_CYCLES(5), .TEAM_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  function automatic logic [6:0] sa(input int t);
    return ia.scores[t*7 +: 7];
  endfunction

  function automatic logic [3:0] sb(input int t);
    return ib.scores[t*4 +: 4];
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] m);
    {b3, b2, b1} = m[2:0];
    umask = m;
`ifdef PLACAR_UNDO_EN
    und = m[3];
`endif
  endtask

  // Press until the score edge, then release and let sync drain.
  task automatic press(
    input logic [3:0] m,
    input logic s,
    input logic [1:0] t
  );
    @(negedge clk);
    set_btn(m);
    sub = s;
    tsel = t;
    repeat (3) @(posedge clk);
    #1;
    set_btn(4'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill(
    input int n3,
    input logic [3:0] last,
    input logic [1:0] t
  );
    repeat (n3) press(4'b0100, 1'b0, t);
    if (last != 4'b0) press(last, 1'b0, t);
  endtask

  // Saturating add on team 1, optional re-hit ext cycles later.
  task automatic buzz_len(
    input logic [3:0] m,
    input int ext,
    output int len
  );
    @(negedge clk);
    set_btn(m);
    sub = 1'b0;
    tsel = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    len = ia.buzzer ? 1 : 0;
    for (int k = 0; k < 5000 && ia.buzzer; k++) begin
      @(negedge clk);
      if (k == 0) set_btn(4'b0);
      if (ext > 0 && k == ext - 3) b1 = 1'b1;
      if (ext > 0 && k == ext + 5) b1 = 1'b0;
      @(posedge clk);
      #1;
      if (ia.buzzer) len++;
    end
    set_btn(4'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    sub = 1'b0;
    tsel = 2'd0;
    set_btn(4'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_scores", ia.scores, 0);
    chk("rst_bcd", ia.bcd, 0);
    chk("rst_inv", ia.invalid_led, 0);
    chk("rst_ovf", ia.overflow_led, 0);
    chk("rst_buzz", ia.buzzer, 0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    b3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("lat_e2", sa(0), 0);
    @(posedge clk);
    #1;
    chk("lat_e3", sa(0), 3);
    chk("bcd_lag", ia.bcd, 0);
    @(posedge clk);
    #1;
    chk("bcd_e4", ia.bcd, 16'h0003);
    b3 = 1'b0;
    repeat (3) @(posedge clk);

    press(4'b0100, 1'b0, 2'd0);
    press(4'b0100, 1'b0, 2'd0);
    chk("add3x3", sa(0), 9);
    chk("bcd9", ia.bcd, 16'h0009);

    fill(32, 4'b0010, 2'd1);
    chk("t1_98", sa(1), 98);
    chk("bcd98", ia.bcd, 16'h9809);

    buzz_len(4'b0010, 0, n);
    chk("sat99", sa(1), 99);
    chk("ovf_set", ia.overflow_led, 1);
    chk("inv_add", ia.invalid_led, 0);
    chk("buzz_len", n, 1000);
    buzz_len(4'b0001, 500, n);
    chk("buzz_ext", n, 1500);
    chk("sat99b", sa(1), 99);

    press(4'b0100, 1'b1, 2'd0);
    press(4'b0100, 1'b1, 2'd0);
    press(4'b0010, 1'b1, 2'd0);
    chk("sub_to1", sa(0), 1);
    press(4'b0010, 1'b1, 2'd0);
    chk("sub_rej", sa(0), 1);
    chk("sub_inv", ia.invalid_led, 1);
    chk("sub_ovf0", ia.overflow_led, 0);
    press(4'b0001, 1'b1, 2'd0);
    chk("sub_to0", sa(0), 0);
    chk("sub_inv0", ia.invalid_led, 0);

    fill(3, 4'b0001, 2'd0);
    chk("t0_10", sa(0), 10);
    @(negedge clk);
    b1 = 1'b1;
    b3 = 1'b1;
    sub = 1'b0;
    tsel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("simul", sa(0), 13);
    repeat (100) @(posedge clk);
    #1;
    chk("held", sa(0), 13);
    set_btn(4'b0);
    repeat (3) @(posedge clk);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2", ia.scores, 0);
    fill(13, 4'b0001, 2'd0);
    fill(18, 4'b0001, 2'd1);
    chk("t0_40", sa(0), 40);
    chk("t1_55", sa(1), 55);

    @(negedge clk);
    b3 = 1'b1;
    sub = 1'b0;
    tsel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_scores", ia.scores, 0);
    chk("clr_inv", ia.invalid_led, 0);
    chk("clr_ovf", ia.overflow_led, 0);
    chk("clr_buzz", ia.buzzer, 0);
    @(negedge clk);
    clr_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("clr_norefire", ia.scores, 0);
    chk("clr_bcd", ia.bcd, 0);
    set_btn(4'b0);
    repeat (3) @(posedge clk);

`ifdef PLACAR_UNDO_EN
    fill(6, 4'b0010, 2'd1);
    chk("u_20", sa(1), 20);
    press(4'b0100, 1'b0, 2'd1);
    chk("u_23", sa(1), 23);
    press(4'b1000, 1'b0, 2'd1);
    chk("u_undo", sa(1), 20);
    chk("u_inv0", ia.invalid_led, 0);
    press(4'b1000, 1'b0, 2'd1);
    chk("u_again", sa(1), 20);
    chk("u_inv1", ia.invalid_led, 1);
`endif

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    press(4'b0001, 1'b0, 2'd3);
    chk("b_sel3_inv", ib.invalid_led, 1);
    chk("b_sel3_sc", ib.scores, 0);
    fill(3, 4'b0, 2'd2);
    chk("b_t2_9", sb(2), 9);
    chk("b_bcd", ib.bcd, 12'h900);
    chk("b_inv0", ib.invalid_led, 0);
    press(4'b0001, 1'b0, 2'd2);
    chk("b_sat", sb(2), 9);
    chk("b_ovf", ib.overflow_led, 1);
    chk("b_buzz", ib.buzzer, 1);
    @(negedge clk);
    clr_b = 1'b1;
    @(posedge clk);
    #1;
    chk("b_clr_buzz", ib.buzzer, 0);
    chk("b_clr_ovf", ib.overflow_led, 0);
    chk("b_clr_sc", ib.scores, 0);
    @(negedge clk);
    clr_b = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b_buzz_idle", ib.buzzer, 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule

// File: doc/placar_basquete_n.md
Name: placar_basquete_n

Overview:
Parametrised, clocked successor to the combinational scoreboard adder/subtractor. It holds one registered score per team and applies +1/+2/+3 or −1/−2/−3 on debounced button edges. It rejects invalid subtractions with an LED and saturates at SCORE_MAX, raising an overflow LED and a timed buzzer. Registered BCD digits per team feed the existing 7-segment decoders downstream.

Parameters:
NUM_TIMES, 2, number of teams/score registers (>=2)
SCORE_W, 7, score register width in bits
SCORE_MAX, 99, saturation ceiling; must satisfy SCORE_MAX < 2^SCORE_W and SCORE_MAX < 10^DIGITS
DIGITS, 2, BCD digits per team
BUZZ_CYCLES, 1000, buzzer on-time in clk cycles (>=1)
TEAM_W, 1, width of team_sel; 2^TEAM_W >= NUM_TIMES

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
btn_1  input  1  async level, +/-1 point button, active-high
btn_2  input  1  async level, +/-2 points
btn_3  input  1  async level, +/-3 points
subtract  input  1  0 = add, 1 = subtract; sampled on event cycle
team_sel  input  TEAM_W  target team; sampled on event cycle
clear  input  1  synchronous clear of all scores and flags
scores  output  NUM_TIMES*SCORE_W  packed binary scores, team 0 in LSBs
bcd  output  NUM_TIMES*DIGITS*4  packed BCD, team 0 in LSBs, units digit lowest
invalid_led  output  1  sticky: last event rejected
overflow_led  output  1  sticky: last add saturated
buzzer  output  1  high for BUZZ_CYCLES after a saturating add

Behaviour:
- Reset (rst_n=0 at clk edge): all scores=0, bcd=0, invalid_led=0, overflow_led=0, buzzer=0, synchronisers=0, buzzer FSM=IDLE.
- Each btn_k passes through a 2-flop synchroniser plus a history flop. An event fires when the synced value is 1 and the history is 0. Holding a button gives exactly one event.
- Latency: btn high before edge 1 -> score updated at edge 3; bcd updated at edge 4.
- Simultaneous rising edges: priority btn_3 > btn_2 > btn_1. Lower-priority edges are consumed, not queued.
- Add: new = score + v. If new > SCORE_MAX, score = SCORE_MAX, overflow_led=1, buzzer starts. Otherwise score = new and overflow_led=0. invalid_led=0 in both cases.
- Subtract: if score < v, score is unchanged and invalid_led=1. Otherwise score = score − v and invalid_led=0. overflow_led=0 in both cases.
- team_sel >= NUM_TIMES: event ignored, invalid_led=1.
- Arithmetic is done at SCORE_W+2 bits; no wrap-around is ever visible.
- Buzzer FSM:
  - IDLE -> BUZZ on a saturating add; counter loads BUZZ_CYCLES−1 and buzzer=1.
  - BUZZ decrements each cycle; at counter 0 -> IDLE and buzzer=0.
  - A saturating add during BUZZ reloads the counter.
- clear=1: on that edge, scores=0, both LEDs=0, buzzer FSM=IDLE. Any event in the same cycle is dropped. Synchronisers keep running, so a held button does not re-fire after clear.
- Reset mid-buzz or mid-event: reset wins and all state returns to reset values.
- bcd is registered binary-to-BCD of each score (double-dabble or divide-free compare/subtract), one-cycle latency.

Optional Feature:
PLACAR_UNDO_EN
- With macro: adds input undo (1 bit, synchronised and edge-detected like the buttons, lowest priority among events).
  - A one-deep history register holds the team and previous score of the last applied event.
  - undo restores that score and invalidates the history. Rejected events do not overwrite history.
  - undo with empty history sets invalid_led=1.
  - clear and reset empty the history.
- Without macro: no undo port, no history register; behaviour otherwise identical.

Test Plan:
- Reset, then team 0 btn_3 add x3 -> scores[team0]=9 at edge 3 of each press, bcd=0x09.
- Team 1 score 98, btn_2 add -> score 99, overflow_led=1, buzzer high exactly BUZZ_CYCLES cycles; second btn_1 add at cycle 500 -> buzzer extends to 500+BUZZ_CYCLES.
- Team 0 score 1, subtract btn_2 -> score stays 1, invalid_led=1; then subtract btn_1 -> score 0, invalid_led=0.
- btn_1 and btn_3 rise same cycle, add, team 0 from 10 -> 13 (single event); holding both 100 cycles -> no further change.
- clear asserted same cycle as an event edge, scores 40/55 -> both 0, LEDs 0, buzzer 0, event dropped; team_sel=3 with NUM_TIMES=3, TEAM_W=2 -> ignored, invalid_led=1.
- PLACAR_UNDO_EN: team 1 from 20, add btn_3 -> 23, undo -> 20, undo again -> 20 with invalid_led=1.
